// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS control unit.
//   state_t      - controller state encoding (4 bits, FETCH = 0)
//   OP_*         - opcode field values (instr[31:26])
//   F_*          - R-type funct field values (instr[5:0])
//   ALU_*        - ALU control encodings driven on alucont
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: combinational R-type funct -> ALU control decoder.
// Ports:
//   funct   in  6  function field of the current instruction
//   alucont out 3  ALU operation (ALU_ADD for an unrecognised funct)
//   valid   out 1  1 when funct is one of add/sub/and/or/slt
module mc_aludec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucont,
  output logic       valid
);

  always_comb begin
    alucont = ALU_ADD;
    valid   = 1'b1;
    case (funct)
      F_ADD:   alucont = ALU_ADD;
      F_SUB:   alucont = ALU_SUB;
      F_AND:   alucont = ALU_AND;
      F_OR:    alucont = ALU_OR;
      F_SLT:   alucont = ALU_SLT;
      default: valid   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM sequencing each MIPS instruction through
// fetch / decode / execute / memory / writeback on the multicycle datapath.
// Ports:
//   clk, reset (async, active-high -> FETCH)
//   op, funct  instruction fields, held stable by the IR after FETCH
//   zero       ALU zero flag, used combinationally for branches
//   pcen, irwrite, memwrite, iord, regwrite, alusrca, alusrcb, memtoreg,
//   regdst, pcsrc, alucont   datapath controls (state-decoded; pcen also
//                            depends on zero)
//   state      current state for debug
// Build option: define MC_BNE_EN to add bne (opcode 000101) via BNEEX.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] pcsrc,
  output logic [2:0] alucont,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic [2:0] rtype_alucont;
  logic       rtype_valid;
  logic       pcwrite;
  logic       branch;
  logic       branch_ne;

  mc_aludec u_aludec (
    .funct   (funct),
    .alucont (rtype_alucont),
    .valid   (rtype_valid)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = BNEEX;
`endif
          default:      state_d = FETCH;  // unsupported opcode runs as a nop
        endcase
      end
      MEMADR: begin
        if (op == OP_LW)      state_d = MEMRD;
        else if (op == OP_SW) state_d = MEMWR;
        else                  state_d = FETCH;
      end
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = rtype_valid ? RTYPEWB : FETCH;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Output decode (pcen is the only output that also looks at zero)
  always_comb begin
    pcwrite   = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    irwrite   = 1'b0;
    memwrite  = 1'b0;
    iord      = 1'b0;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    memtoreg  = 1'b0;
    regdst    = 1'b0;
    pcsrc     = 2'b00;
    alucont   = ALU_ADD;
    case (state_q)
      FETCH: begin
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
        pcsrc   = 2'b01;
      end
      DECODE:  alusrcb = 2'b11;  // latch branch target into aluout
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        alucont = rtype_alucont;
      end
      RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        alucont = ALU_SUB;
        branch  = 1'b1;
      end
`ifdef MC_BNE_EN
      BNEEX: begin
        alusrca   = 1'b1;
        alucont   = ALU_SUB;
        branch_ne = 1'b1;
      end
`endif
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:  regwrite = 1'b1;
      JEX: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
      default: ;
    endcase
    pcen = pcwrite | (branch & zero) | (branch_ne & ~zero);
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected {state, controls}
// are queued when an instruction is launched and popped each cycle.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pcen, irwrite, memwrite, iord, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       memtoreg, regdst;
  logic [2:0] alucont;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  st;
    logic [14:0] ctl;
  } exp_t;
  exp_t sb[$];

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                 S_MEMWB = 4, S_MEMWR = 5, S_RTEX = 6, S_RTWB = 7,
                 S_BEQ = 8, S_ADDIEX = 9, S_ADDIWB = 10, S_JEX = 11,
                 S_BNE = 12;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .iord(iord),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .memtoreg(memtoreg), .regdst(regdst), .pcsrc(pcsrc),
    .alucont(alucont), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] mk(logic pe, logic irw, logic mw, logic io,
                                     logic rw, logic asa, logic [1:0] asb,
                                     logic m2r, logic rd, logic [1:0] ps,
                                     logic [2:0] alu);
    return {pe, irw, mw, io, rw, asa, asb, m2r, rd, ps, alu};
  endfunction

  // Expected controls per state, written directly from the control table.
  function automatic logic [14:0] exp_ctl(int s, logic z, logic [2:0] rt_alu);
    case (s)
      S_FETCH:  return mk(1,1,0,0,0,0,2'b01,0,0,2'b01,3'b010);
      S_DECODE: return mk(0,0,0,0,0,0,2'b11,0,0,2'b00,3'b010);
      S_MEMADR: return mk(0,0,0,0,0,1,2'b10,0,0,2'b00,3'b010);
      S_MEMRD:  return mk(0,0,0,1,0,0,2'b00,0,0,2'b00,3'b010);
      S_MEMWB:  return mk(0,0,0,0,1,0,2'b00,1,0,2'b00,3'b010);
      S_MEMWR:  return mk(0,0,1,1,0,0,2'b00,0,0,2'b00,3'b010);
      S_RTEX:   return mk(0,0,0,0,0,1,2'b00,0,0,2'b00,rt_alu);
      S_RTWB:   return mk(0,0,0,0,1,0,2'b00,0,1,2'b00,3'b010);
      S_BEQ:    return mk(z,0,0,0,0,1,2'b00,0,0,2'b00,3'b110);
      S_ADDIEX: return mk(0,0,0,0,0,1,2'b10,0,0,2'b00,3'b010);
      S_ADDIWB: return mk(0,0,0,0,1,0,2'b00,0,0,2'b00,3'b010);
      S_JEX:    return mk(1,0,0,0,0,0,2'b00,0,0,2'b10,3'b010);
      S_BNE:    return mk(~z,0,0,0,0,1,2'b00,0,0,2'b00,3'b110);
      default:  return 15'h7fff;
    endcase
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic logic [14:0] dut_ctl();
    return {pcen, irwrite, memwrite, iord, regwrite, alusrca, alusrcb,
            memtoreg, regdst, pcsrc, alucont};
  endfunction

  task automatic pop_check(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check_eq({tag, "_state"}, {28'd0, state}, {28'd0, e.st});
    check_eq({tag, "_ctl"}, {17'd0, dut_ctl()}, {17'd0, e.ctl});
  endtask

  // Launch one instruction at a negedge while in FETCH; checks every cycle
  // and returns at the negedge of the next FETCH.
  task automatic run(string name, logic [5:0] o, logic [5:0] f, logic z,
                     int n, int seq[6], logic [2:0] rt_alu);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.st  = seq[i][3:0];
      e.ctl = exp_ctl(seq[i], z, rt_alu);
      sb.push_back(e);
    end
    op = o; funct = f; zero = z;
    for (int i = 0; i < n; i++) begin
      pop_check($sformatf("%s_c%0d", name, i));
      @(posedge clk);
      @(negedge clk);
    end
    check_eq({name, "_end_fetch"}, {28'd0, state}, 32'd0);
    $display("[TB] %s op=%b funct=%b zero=%0d cycles=%0d", name, o, f, z, n);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;
    #1;
    e.st = 4'd0; e.ctl = exp_ctl(S_FETCH, 1'b0, 3'b010);
    sb.push_back(e);
    pop_check("reset");
    $display("[TB] reset state=%0d", state);
    @(negedge clk);
    reset = 1'b0;

    run("lw",    6'b100011, 6'b000000, 1'b0, 5, '{0,1,2,3,4,0}, 3'b010);
    run("sw",    6'b101011, 6'b000000, 1'b0, 4, '{0,1,2,5,0,0}, 3'b010);
    run("r_add", 6'b000000, 6'b100000, 1'b0, 4, '{0,1,6,7,0,0}, 3'b010);
    run("r_sub", 6'b000000, 6'b100010, 1'b0, 4, '{0,1,6,7,0,0}, 3'b110);
    run("r_and", 6'b000000, 6'b100100, 1'b0, 4, '{0,1,6,7,0,0}, 3'b000);
    run("r_or",  6'b000000, 6'b100101, 1'b0, 4, '{0,1,6,7,0,0}, 3'b001);
    run("r_slt", 6'b000000, 6'b101010, 1'b0, 4, '{0,1,6,7,0,0}, 3'b111);
    run("r_bad", 6'b000000, 6'b000111, 1'b0, 3, '{0,1,6,0,0,0}, 3'b010);
    run("beq_t", 6'b000100, 6'b000000, 1'b1, 3, '{0,1,8,0,0,0}, 3'b010);
    run("beq_n", 6'b000100, 6'b000000, 1'b0, 3, '{0,1,8,0,0,0}, 3'b010);
    run("addi",  6'b001000, 6'b000000, 1'b0, 4, '{0,1,9,10,0,0}, 3'b010);
    run("j",     6'b000010, 6'b000000, 1'b0, 3, '{0,1,11,0,0,0}, 3'b010);
    run("nop",   6'b111111, 6'b000000, 1'b0, 2, '{0,1,0,0,0,0}, 3'b010);
`ifdef MC_BNE_EN
    run("bne_t", 6'b000101, 6'b000000, 1'b0, 3, '{0,1,12,0,0,0}, 3'b010);
    run("bne_n", 6'b000101, 6'b000000, 1'b1, 3, '{0,1,12,0,0,0}, 3'b010);
`else
    run("bne_nop", 6'b000101, 6'b000000, 1'b0, 2, '{0,1,0,0,0,0}, 3'b010);
`endif

    // Reset asserted mid-MEMRD of a lw aborts it immediately.
    op = 6'b100011; funct = 6'b0; zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    e.st = 4'd3; e.ctl = exp_ctl(S_MEMRD, 1'b0, 3'b010);
    sb.push_back(e);
    pop_check("pre_reset_memrd");
    reset = 1'b1;
    #1;
    e.st = 4'd0; e.ctl = exp_ctl(S_FETCH, 1'b0, 3'b010);
    sb.push_back(e);
    pop_check("mid_reset");
    check_eq("mid_reset_memwrite", {31'd0, memwrite}, 32'd0);
    check_eq("mid_reset_regwrite", {31'd0, regwrite}, 32'd0);
    $display("[TB] mid-MEMRD reset state=%0d irwrite=%0d", state, irwrite);
    @(negedge clk);
    reset = 1'b0;
    run("lw_after_rst", 6'b100011, 6'b000000, 1'b0, 5, '{0,1,2,3,4,0}, 3'b010);

    check_eq("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
